// File: rtl/pl_id_ex_reg.sv
// ---------------------------------------------------------------------------
// pl_id_ex_reg
//   ID/EX pipeline register for the 8-bit RNS pipeline, feeding the EX-stage
//   ALU. Each source operand is resolved by forwarding from EX, MEM and WB
//   (EX has the highest priority). The immediate is reduced into the %MOD
//   domain. A load-use hazard inserts a bubble into EX and stalls ID for one
//   cycle, so the dependent instruction can pick up the load data from MEM.
//
// Ports
//   i_clk, i_rst_n         pipeline clock, async active-low reset
//   i_id_*                 decoded ID-stage instruction and register reads
//   i_alu_result           combinational ALU output of the instruction in EX
//   i_mem_* / i_wb_*       MEM / WB stage writeback candidates for forwarding
//   i_ex_hold              downstream stall, freezes this register
//   i_flush                kills the instruction entering EX
//   o_ex_*                 registered EX-stage fields driving the ALU
//   o_stall_id             combinational, hold PC and IF/ID this cycle
// ---------------------------------------------------------------------------
module pl_id_ex_reg #(
  parameter int MOD  = 129,
  parameter int NREG = 8,
  parameter int RW   = $clog2(NREG)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,

  input  logic          i_id_valid,
  input  logic [2:0]    i_id_opcode,
  input  logic [RW-1:0] i_id_rs1,
  input  logic [RW-1:0] i_id_rs2,
  input  logic [RW-1:0] i_id_rd,
  input  logic          i_id_rd_we,
  input  logic          i_id_is_load,
  input  logic          i_id_use_imm,
  input  logic [7:0]    i_id_imm,
  input  logic [7:0]    i_id_rs1_data,
  input  logic [7:0]    i_id_rs2_data,
  input  logic          i_id_carry_in,

  input  logic [7:0]    i_alu_result,

  input  logic          i_mem_valid,
  input  logic          i_mem_rd_we,
  input  logic [RW-1:0] i_mem_rd,
  input  logic [7:0]    i_mem_data,

  input  logic          i_wb_valid,
  input  logic          i_wb_rd_we,
  input  logic [RW-1:0] i_wb_rd,
  input  logic [7:0]    i_wb_data,

  input  logic          i_ex_hold,
  input  logic          i_flush,

  output logic          o_ex_valid,
  output logic [2:0]    o_ex_opcode,
  output logic [7:0]    o_ex_op1,
  output logic [7:0]    o_ex_op2,
  output logic          o_ex_carry_in,
  output logic [RW-1:0] o_ex_rd,
  output logic          o_ex_rd_we,
  output logic          o_ex_is_load,
  output logic          o_stall_id
);

  localparam logic [7:0] MOD_W = 8'(MOD);

  logic          r_ex_valid;
  logic [2:0]    r_ex_opcode;
  logic [7:0]    r_ex_op1;
  logic [7:0]    r_ex_op2;
  logic          r_ex_carry_in;
  logic [RW-1:0] r_ex_rd;
  logic          r_ex_rd_we;
  logic          r_ex_is_load;

  logic          w_ex_fwd_ok;
  logic          w_mem_fwd_ok;
  logic          w_wb_fwd_ok;
  logic [7:0]    w_rs1_val;
  logic [7:0]    w_rs2_val;
  logic [7:0]    w_imm_red;
  logic [7:0]    w_op2;
  logic          w_hz;
  logic          w_kill;

  // A load in EX has no result yet, so it must never forward from alu_result;
  // that case is covered by the load-use stall instead.
  assign w_ex_fwd_ok  = r_ex_valid & r_ex_rd_we & ~r_ex_is_load;
  assign w_mem_fwd_ok = i_mem_valid & i_mem_rd_we;
  assign w_wb_fwd_ok  = i_wb_valid & i_wb_rd_we;

  always_comb begin
    w_rs1_val = i_id_rs1_data;
    if (i_id_rs1 == '0)
      w_rs1_val = 8'h00;
    else if (w_ex_fwd_ok && (r_ex_rd == i_id_rs1))
      w_rs1_val = i_alu_result;
    else if (w_mem_fwd_ok && (i_mem_rd == i_id_rs1))
      w_rs1_val = i_mem_data;
    else if (w_wb_fwd_ok && (i_wb_rd == i_id_rs1))
      w_rs1_val = i_wb_data;
  end

  always_comb begin
    w_rs2_val = i_id_rs2_data;
    if (i_id_rs2 == '0)
      w_rs2_val = 8'h00;
    else if (w_ex_fwd_ok && (r_ex_rd == i_id_rs2))
      w_rs2_val = i_alu_result;
    else if (w_mem_fwd_ok && (i_mem_rd == i_id_rs2))
      w_rs2_val = i_mem_data;
    else if (w_wb_fwd_ok && (i_wb_rd == i_id_rs2))
      w_rs2_val = i_wb_data;
  end

  // One conditional subtract is enough: 255 - MOD < MOD.
  assign w_imm_red = (i_id_imm >= MOD_W) ? (i_id_imm - MOD_W) : i_id_imm;
  assign w_op2     = i_id_use_imm ? w_imm_red : w_rs2_val;

  // rs2 is ignored only when the immediate replaces it; opcode plays no part.
  assign w_hz = i_id_valid & r_ex_valid & r_ex_is_load & r_ex_rd_we &
                (r_ex_rd != '0) &
                ((r_ex_rd == i_id_rs1) | (~i_id_use_imm & (r_ex_rd == i_id_rs2)));

  assign w_kill = i_flush | w_hz;

  // Gated by reset so a hold asserted during reset does not leak out.
  assign o_stall_id = i_rst_n & (i_ex_hold | (~i_flush & w_hz));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ex_valid    <= 1'b0;
      r_ex_opcode   <= 3'b000;
      r_ex_op1      <= 8'h00;
      r_ex_op2      <= 8'h00;
      r_ex_carry_in <= 1'b0;
      r_ex_rd       <= '0;
      r_ex_rd_we    <= 1'b0;
      r_ex_is_load  <= 1'b0;
    end else if (!i_ex_hold) begin
      if (w_kill) begin
        // Flush or load-use bubble: only the control bits matter, data fields
        // keep their old values since nothing downstream looks at them.
        r_ex_valid   <= 1'b0;
        r_ex_rd_we   <= 1'b0;
        r_ex_is_load <= 1'b0;
      end else begin
        r_ex_valid    <= i_id_valid;
        r_ex_rd_we    <= i_id_rd_we & i_id_valid;
        r_ex_is_load  <= i_id_is_load & i_id_valid;
        r_ex_opcode   <= i_id_opcode;
        r_ex_op1      <= w_rs1_val;
        r_ex_op2      <= w_op2;
        r_ex_carry_in <= i_id_carry_in;
        r_ex_rd       <= i_id_rd;
      end
    end
  end

  assign o_ex_valid    = r_ex_valid;
  assign o_ex_opcode   = r_ex_opcode;
  assign o_ex_op1      = r_ex_op1;
  assign o_ex_op2      = r_ex_op2;
  assign o_ex_carry_in = r_ex_carry_in;
  assign o_ex_rd       = r_ex_rd;
  assign o_ex_rd_we    = r_ex_rd_we;
  assign o_ex_is_load  = r_ex_is_load;

endmodule
